shifter_pipe: RTL and testbench
===============================

// Module: shifter_pipe
// PURPOSE
//   Parametrised, pipelined barrel shifter for the execute stage. It supports
//   SLL, SRA, ROR and a new SRL mode, with configurable WIDTH and register
//   depth (STAGES).
//   valid/ready handshake with backpressure, a synchronous flush, and a
//   sideband tag carried alongside each operation. It replaces the
//   single-cycle 16-bit combinational shifter wherever the shift path limits timing.
// PARAMETERS
//   WIDTH    16  data width; power of 2, >= 4
//   SHAMT_W  $clog2(WIDTH)  shift-amount width (derived, do not override)
//   STAGES   1   pipeline register stages, 1..SHAMT_W; latency = STAGES cycles
//   TAG_W    4   sideband tag width (dest reg id etc.), passed through unchanged
// PORTS
//   clk        in   1        clock, all state on rising edge
//   rst_n      in   1        asynchronous active-low reset
//   flush      in   1        synchronous kill of all in-flight ops
//   in_valid   in   1        operation presented
//   in_ready   out  1        block can accept this cycle
//   in_data    in   WIDTH    operand
//   in_shamt   in   SHAMT_W  shift amount, unsigned
//   in_mode    in   2        shift_mode_e: 00 SLL, 01 SRA, 10 ROR, 11 SRL
//   in_tag     in   TAG_W    sideband tag
//   out_valid  out  1        result available
//   out_ready  in   1        consumer accepts result
//   out_data   out  WIDTH    shifted result
//   out_zero   out  1        out_data == 0
//   out_tag    out  TAG_W    tag of the op in out_data
// BEHAVIOUR
//   - Log shifter: SHAMT_W log-stages. Log-stage k applies a shift of 2^k when
//     shamt[k]=1. Log-stages are evaluated from MSB (k=SHAMT_W-1) down to 0.
//     Mode, remaining shamt and tag travel with the data.
//   - Fill rules: SLL fills 0 from the LSB. SRL fills 0 from the MSB. SRA
//     replicates the ORIGINAL operand bit WIDTH-1, which is carried as a
//     registered sign bit. ROR rotates with no loss. shamt=0 passes the operand
//     through in every mode.
//   - Registers: register boundary s (0..STAGES-1) sits after log-stage index
//     (SHAMT_W-1) - (floor((s+1)*SHAMT_W/STAGES)-1). The last boundary is the
//     output register. Latency is exactly STAGES cycles from the accept edge
//     to out_valid, with no combinational in->out path.
//   - Handshake: an input transfer occurs when in_valid && in_ready. An output
//     transfer occurs when out_valid && out_ready.
//   - Stall: stall = out_valid && !out_ready. While stalled, every stage holds,
//     and in_ready = !stall && !flush. When not stalled, all stages advance
//     together and empty slots propagate as bubbles (valid=0).
//   - Output stability: out_data, out_tag and out_zero hold stable while
//     out_valid && !out_ready.
//   - Flush: on the rising edge with flush=1, all stage valid bits clear and
//     the op presented on that cycle is not accepted. out_valid=0 on the
//     following cycle. Flush overrides stall.
//   - Reset (async, any time, including mid-operation): all valid bits = 0,
//     out_valid=0, out_data=0, out_tag=0, out_zero=0. Data registers also
//     reset to 0. in_ready=1 after reset release.
//   - Throughput: one op per cycle when out_ready stays high. A full pipeline
//     with out_ready=0 holds STAGES ops, with no loss and no duplication.
//   - out_zero is registered with out_data and not recomputed at the output.
// STRUCTURE
//   - shifter_pkg: typedef enum logic [1:0] shift_mode_e {SH_SLL, SH_SRA,
//     SH_ROR, SH_SRL}, and a function shift_step(data, sign, mode, amt) for one
//     power-of-2 shift.
//   - Sub-module shift_stage #(WIDTH, SHIFT): one combinational log-stage, used
//     via a generate loop over k. The top level owns the pipeline registers,
//     the valid bits and stall/flush.
// TESTING (WIDTH=16, STAGES=2 unless noted)
//   1. SLL 0x00FF, shamt 4 -> out_data 0x0FF0, out_valid exactly 2 cycles after accept.
//   2. 0x8010 shamt 4: SRA -> 0xF801; SRL -> 0x0801. 0x8000 SRA 15 -> 0xFFFF.
//   3. ROR 0x1234: shamt 4 -> 0x4123; shamt 0 -> 0x1234; shamt 15 -> 0x2468.
//      SLL 0x8000 shamt 1 -> 0x0000 with out_zero=1.
//   4. Back-to-back 4 ops with out_ready=0 for 3 cycles -> in_ready drops,
//      results and tags exit in order, none lost or duplicated.
//   5. flush while 2 ops in flight and in_valid=1 -> no output for those ops;
//      the next accepted op returns a correct result at 2-cycle latency.
//   6. rst_n low mid-stream -> out_valid/out_data/out_tag 0 immediately, with
//      no clock edge required. Sweep WIDTH=32 with STAGES=1 and 5:
//      SRA 0x80000000 shamt 31 -> 0xFFFFFFFF.

Source files
------------

// File: rtl/shifter_pkg.sv
// Shared types and the single power-of-two shift primitive for the pipelined barrel shifter.
package shifter_pkg;

  typedef enum logic [1:0] {
    SH_SLL = 2'b00,
    SH_SRA = 2'b01,
    SH_ROR = 2'b10,
    SH_SRL = 2'b11
  } shift_mode_e;

  localparam int unsigned MaxWidth = 64;
  localparam int unsigned MaxIdxW  = 6;

  // Operates on the low `width` bits of a MaxWidth container; upper result bits stay zero.
  function automatic logic [MaxWidth-1:0] shift_step(input logic [MaxWidth-1:0] data,
                                                     input logic               sign,
                                                     input shift_mode_e        mode,
                                                     input int unsigned        amt,
                                                     input int unsigned        width);
    logic [MaxWidth-1:0] res;
    logic [MaxIdxW-1:0]  idx;
    res = '0;
    idx = '0;
    for (int unsigned i = 0; i < MaxWidth; i++) begin
      if (i < width) begin
        unique case (mode)
          SH_SLL: begin
            idx = MaxIdxW'(i - amt);
            res[MaxIdxW'(i)] = (i >= amt) ? data[idx] : 1'b0;
          end
          SH_SRL: begin
            idx = MaxIdxW'(i + amt);
            res[MaxIdxW'(i)] = (i + amt < width) ? data[idx] : 1'b0;
          end
          SH_SRA: begin
            idx = MaxIdxW'(i + amt);
            res[MaxIdxW'(i)] = (i + amt < width) ? data[idx] : sign;
          end
          default: begin
            idx = MaxIdxW'((i + amt) % width);
            res[MaxIdxW'(i)] = data[idx];
          end
        endcase
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/shift_stage.sv
// One combinational log-stage: applies a fixed shift of SHIFT bits when enabled.
module shift_stage import shifter_pkg::*; #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned SHIFT = 1
) (
  input  logic [WIDTH-1:0] data_i,
  input  logic             sign_i,
  input  shift_mode_e      mode_i,
  input  logic             en_i,
  output logic [WIDTH-1:0] data_o
);

  logic [MaxWidth-1:0] wide_in;
  logic [MaxWidth-1:0] wide_out;

  always_comb begin
    wide_in              = '0;
    wide_in[WIDTH-1:0]   = data_i;
    wide_out             = shift_step(wide_in, sign_i, mode_i, SHIFT, WIDTH);
    data_o               = en_i ? wide_out[WIDTH-1:0] : data_i;
  end

  // Bits above WIDTH are always zero.
  logic unused_wide;
  assign unused_wide = ^wide_out;

endmodule

// File: rtl/shifter_pipe.sv
// Pipelined log barrel shifter (SLL/SRA/ROR/SRL) with valid/ready handshake, flush and tag.
module shifter_pipe import shifter_pkg::*; #(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned SHAMT_W = $clog2(WIDTH),
  parameter int unsigned STAGES  = 1,
  parameter int unsigned TAG_W   = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [SHAMT_W-1:0] in_shamt,
  input  shift_mode_e        in_mode,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_zero,
  output logic [TAG_W-1:0]   out_tag
);

  logic                           stall;
  logic [STAGES-1:0]              valid_q, valid_d;
  logic [STAGES-1:0]              sign_q, sign_d;
  logic [STAGES-1:0][WIDTH-1:0]   data_q, data_d;
  logic [STAGES-1:0][SHAMT_W-1:0] shamt_q, shamt_d;
  logic [STAGES-1:0][1:0]         mode_q, mode_d;
  logic [STAGES-1:0][TAG_W-1:0]   tag_q, tag_d;
  logic                           zero_q, zero_d;

  assign stall    = valid_q[STAGES-1] & ~out_ready;
  assign in_ready = ~stall & ~flush;

  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    // Register s closes the segment of log-stages [Lo, Hi) counted from the MSB stage.
    localparam int unsigned Lo = (s * SHAMT_W) / STAGES;
    localparam int unsigned Hi = ((s + 1) * SHAMT_W) / STAGES;
    localparam int unsigned N  = Hi - Lo;

    logic [WIDTH-1:0]   src_data;
    logic               src_sign;
    logic               src_valid;
    shift_mode_e        src_mode;
    logic [SHAMT_W-1:0] src_shamt;
    logic [TAG_W-1:0]   src_tag;
    logic [N:0][WIDTH-1:0] seg;

    if (s == 0) begin : g_head
      assign src_data  = in_data;
      assign src_sign  = in_data[WIDTH-1];
      assign src_valid = in_valid & in_ready;
      assign src_mode  = in_mode;
      assign src_shamt = in_shamt;
      assign src_tag   = in_tag;
    end else begin : g_body
      assign src_data  = data_q[s-1];
      assign src_sign  = sign_q[s-1];
      assign src_valid = valid_q[s-1];
      assign src_mode  = shift_mode_e'(mode_q[s-1]);
      assign src_shamt = shamt_q[s-1];
      assign src_tag   = tag_q[s-1];
    end

    assign seg[0] = src_data;

    for (genvar m = 0; m < N; m++) begin : g_log
      localparam int unsigned K = SHAMT_W - 1 - (Lo + m);
      shift_stage #(
        .WIDTH (WIDTH),
        .SHIFT (1 << K)
      ) u_shift_stage (
        .data_i (seg[m]),
        .sign_i (src_sign),
        .mode_i (src_mode),
        .en_i   (src_shamt[K]),
        .data_o (seg[m+1])
      );
    end

    assign valid_d[s] = flush ? 1'b0 : (stall ? valid_q[s] : src_valid);
    assign data_d[s]  = seg[N];
    assign sign_d[s]  = src_sign;
    assign mode_d[s]  = src_mode;
    assign shamt_d[s] = src_shamt;
    assign tag_d[s]   = src_tag;
  end

  assign zero_d = ~|data_d[STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      data_q  <= '0;
      sign_q  <= '0;
      mode_q  <= '0;
      shamt_q <= '0;
      tag_q   <= '0;
      zero_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      if (!stall) begin
        data_q  <= data_d;
        sign_q  <= sign_d;
        mode_q  <= mode_d;
        shamt_q <= shamt_d;
        tag_q   <= tag_d;
        zero_q  <= zero_d;
      end
    end
  end

  assign out_valid = valid_q[STAGES-1];
  assign out_data  = data_q[STAGES-1];
  assign out_tag   = tag_q[STAGES-1];
  assign out_zero  = zero_q;

  // Shift controls are consumed a few bits per stage; the last stage needs none of them.
  logic unused_ctrl;
  assign unused_ctrl = ^{shamt_q, mode_q[STAGES-1], sign_q[STAGES-1]};

endmodule

// File: tb/tb_shifter_pipe.sv
// Directed self-checking bench: 16-bit/2-stage main instance plus 32-bit 1- and 5-stage instances.
module tb_shifter_pipe;
  import shifter_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_data = '0;
  logic [3:0]  in_shamt = '0;
  shift_mode_e in_mode = SH_SLL;
  logic [3:0]  in_tag = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] out_data;
  logic        out_zero;
  logic [3:0]  out_tag;

  logic        w_valid = 1'b0;
  logic [31:0] w_data = '0;
  logic [4:0]  w_shamt = '0;
  shift_mode_e w_mode = SH_SLL;
  logic [3:0]  w_tag = '0;
  logic        w1_in_ready, w1_valid, w1_zero, w5_in_ready, w5_valid, w5_zero;
  logic [31:0] w1_data, w5_data;
  logic [3:0]  w1_tag, w5_tag;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  shifter_pipe #(.WIDTH(16), .STAGES(2), .TAG_W(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_shamt(in_shamt), .in_mode(in_mode), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_zero(out_zero),
    .out_tag(out_tag)
  );

  shifter_pipe #(.WIDTH(32), .STAGES(1), .TAG_W(4)) u_dut_w1 (
    .clk(clk), .rst_n(rst_n), .flush(1'b0), .in_valid(w_valid), .in_ready(w1_in_ready),
    .in_data(w_data), .in_shamt(w_shamt), .in_mode(w_mode), .in_tag(w_tag),
    .out_valid(w1_valid), .out_ready(1'b1), .out_data(w1_data), .out_zero(w1_zero),
    .out_tag(w1_tag)
  );

  shifter_pipe #(.WIDTH(32), .STAGES(5), .TAG_W(4)) u_dut_w5 (
    .clk(clk), .rst_n(rst_n), .flush(1'b0), .in_valid(w_valid), .in_ready(w5_in_ready),
    .in_data(w_data), .in_shamt(w_shamt), .in_mode(w_mode), .in_tag(w_tag),
    .out_valid(w5_valid), .out_ready(1'b1), .out_data(w5_data), .out_zero(w5_zero),
    .out_tag(w5_tag)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Single op through the main instance with out_ready high; checks 2-cycle latency.
  task automatic run_op(input logic [15:0] d, input logic [3:0] sh, input shift_mode_e m,
                        input logic [3:0] t, input logic [15:0] e);
    @(negedge clk);
    in_valid = 1'b1; in_data = d; in_shamt = sh; in_mode = m; in_tag = t;
    @(negedge clk);
    in_valid = 1'b0;
    check("lat1_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    check("op_valid", 32'(out_valid), 32'd1);
    check("op_data", 32'(out_data), 32'(e));
    check("op_zero", 32'(out_zero), 32'(e == 16'h0));
    check("op_tag", 32'(out_tag), 32'(t));
  endtask

  task automatic wide_op(input logic [31:0] d, input logic [4:0] sh, input shift_mode_e m,
                         input logic [3:0] t, input logic [31:0] e);
    @(negedge clk);
    w_valid = 1'b1; w_data = d; w_shamt = sh; w_mode = m; w_tag = t;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      w_valid = 1'b0;
      if (c == 1) begin
        check("w1_valid", 32'(w1_valid), 32'd1);
        check("w1_data", w1_data, e);
        check("w1_tag", 32'(w1_tag), 32'(t));
      end
      if (c == 4) check("w5_early", 32'(w5_valid), 32'd0);
      if (c == 5) begin
        check("w5_valid", 32'(w5_valid), 32'd1);
        check("w5_data", w5_data, e);
        check("w5_zero", 32'(w5_zero), 32'(e == 32'h0));
      end
    end
  endtask

  logic [15:0] st_data [4] = '{16'h0001, 16'hF000, 16'h000F, 16'h8000};
  logic [3:0]  st_sh   [4] = '{4'd1, 4'd4, 4'd4, 4'd1};
  shift_mode_e st_mode [4] = '{SH_SLL, SH_SRL, SH_ROR, SH_SRA};
  logic [15:0] st_exp  [4] = '{16'h0002, 16'h0F00, 16'hF000, 16'hC000};
  logic [15:0] exp_data_q [$];
  logic [3:0]  exp_tag_q [$];

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int sent;
    int got;
    logic saw_block;

    #12;
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_data", 32'(out_data), 32'd0);
    check("rst_tag", 32'(out_tag), 32'd0);
    check("rst_zero", 32'(out_zero), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("rst_in_ready", 32'(in_ready), 32'd1);

    run_op(16'h00FF, 4'd4,  SH_SLL, 4'h1, 16'h0FF0);
    run_op(16'h8010, 4'd4,  SH_SRA, 4'h2, 16'hF801);
    run_op(16'h8010, 4'd4,  SH_SRL, 4'h3, 16'h0801);
    run_op(16'h8000, 4'd15, SH_SRA, 4'h4, 16'hFFFF);
    run_op(16'h1234, 4'd4,  SH_ROR, 4'h5, 16'h4123);
    run_op(16'h1234, 4'd0,  SH_ROR, 4'h6, 16'h1234);
    run_op(16'h1234, 4'd15, SH_ROR, 4'h7, 16'h2468);
    run_op(16'h8000, 4'd1,  SH_SLL, 4'h8, 16'h0000);
    run_op(16'hFFFF, 4'd15, SH_SRL, 4'h9, 16'h0001);
    run_op(16'h7FF0, 4'd4,  SH_SRA, 4'hA, 16'h07FF);

    // Back-to-back stream with three cycles of backpressure.
    sent = 0; got = 0; saw_block = 1'b0;
    for (int cyc = 0; cyc < 30 && got < 4; cyc++) begin
      @(negedge clk);
      out_ready = !(cyc >= 2 && cyc < 5);
      in_valid = (sent < 4);
      if (sent < 4) begin
        in_data = st_data[sent]; in_shamt = st_sh[sent]; in_mode = st_mode[sent];
        in_tag = 4'(sent + 3);
      end
      #1;
      if (in_valid && !in_ready) saw_block = 1'b1;
      if (out_valid) begin
        if (exp_data_q.size() == 0) begin
          check("stream_extra", 32'd1, 32'd0);
        end else begin
          check("stream_data", 32'(out_data), 32'(exp_data_q[0]));
          check("stream_tag", 32'(out_tag), 32'(exp_tag_q[0]));
          if (out_ready) begin
            void'(exp_data_q.pop_front());
            void'(exp_tag_q.pop_front());
            got++;
          end
        end
      end
      if (in_valid && in_ready) begin
        exp_data_q.push_back(st_exp[sent]);
        exp_tag_q.push_back(4'(sent + 3));
        sent++;
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    check("stream_count", 32'(got), 32'd4);
    check("stream_in_ready_drop", 32'(saw_block), 32'd1);

    // Flush with two ops in flight (one stalled at the output) and a new op offered.
    @(negedge clk);
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 16'h0003; in_shamt = 4'd1; in_mode = SH_SLL; in_tag = 4'hB;
    @(negedge clk);
    in_data = 16'h0005; in_tag = 4'hC;
    @(negedge clk);
    check("pre_flush_valid", 32'(out_valid), 32'd1);
    flush = 1'b1; in_data = 16'h0007; in_tag = 4'hD;
    #1 check("flush_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    check("post_flush_valid1", 32'(out_valid), 32'd0);
    @(negedge clk);
    check("post_flush_valid2", 32'(out_valid), 32'd0);
    run_op(16'h1234, 4'd8, SH_SRL, 4'hE, 16'h0012);

    // Asynchronous reset in mid-stream.
    @(negedge clk);
    in_valid = 1'b1; in_data = 16'h0F0F; in_shamt = 4'd4; in_mode = SH_SLL; in_tag = 4'h7;
    @(negedge clk);
    in_data = 16'h0001; in_tag = 4'h2;
    @(negedge clk);
    in_valid = 1'b0;
    check("mid_valid", 32'(out_valid), 32'd1);
    check("mid_data", 32'(out_data), 32'hF0F0);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_valid", 32'(out_valid), 32'd0);
    check("async_rst_data", 32'(out_data), 32'd0);
    check("async_rst_tag", 32'(out_tag), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("after_rst_valid", 32'(out_valid), 32'd0);
    check("after_rst_ready", 32'(in_ready), 32'd1);

    wide_op(32'h8000_0000, 5'd31, SH_SRA, 4'h3, 32'hFFFF_FFFF);
    wide_op(32'h1234_5678, 5'd8,  SH_ROR, 4'h4, 32'h7812_3456);
    wide_op(32'h8000_0000, 5'd31, SH_SRL, 4'h5, 32'h0000_0001);
    wide_op(32'h0000_0001, 5'd31, SH_SLL, 4'h6, 32'h8000_0000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
